volume_ramp_sequencer: RTL and testbench
========================================

# volume_ramp_sequencer

Controls the volume and mute inputs of the output conversion stage so that volume changes and mute/unmute never cause steps in the output: volume moves toward a target at most STEP LSBs per output frame, and mute is applied only after the gain has ramped to zero. It sits between the control/register interface and the output converter. Its frame strobe is the converter's output-valid pulse, so every gain change lands on a frame boundary.

## Interface
- STEP, 1, volume LSBs changed per frame tick; legal range 1..255
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- target_vol  in  8  requested volume, unsigned, sampled every cycle
- mute_req  in  1  level; 1 = request mute
- frame_tick  in  1  one-cycle pulse per 44.1 kHz output frame
- volume  out  8  gain to output converter, registered
- mute  out  1  hard mute to output converter, registered
- state  out  2  0=RUN, 1=RAMP_DOWN, 2=MUTED, 3=RAMP_UP
- ramp_busy  out  1  volume not settled
- muted_ack  out  1  1 while in MUTED

## Operation
- Reset values: state=MUTED, volume=0, mute=1, ramp_busy=0, muted_ack=1. The block leaves reset muted so start-up is pop-free.
- Each cycle takes either one state transition or one volume update. A transition has priority, and the cycle that takes it does not change volume.
- Volume step toward target T from current V on a frame_tick: V += min(STEP, T−V) if T>V; V −= min(STEP, V−T) if T<V.
  - Arithmetic is unsigned and saturating, computed at 9 bits.
  - The step never overshoots, wraps, or goes below 0.
- RUN (mute=0):
  - mute_req=1 → RAMP_DOWN.
  - Otherwise, on frame_tick, step toward target_vol.
  - Target changes mid-ramp are tracked continuously.
- RAMP_DOWN (mute=0):
  - mute_req=0 → RAMP_UP.
  - Else if volume==0 → MUTED.
  - Else, on frame_tick, V −= min(STEP, V).
- MUTED (volume=0, mute=1):
  - mute_req=0 → RAMP_UP; mute is registered 0 in the same transition.
  - target_vol changes are ignored.
- RAMP_UP (mute=0):
  - mute_req=1 → RAMP_DOWN.
  - Else if volume ≥ target_vol → RUN. If target_vol is lowered below volume, RUN then ramps it down.
  - Else, on frame_tick, step up toward target_vol.
- ramp_busy = state is RAMP_DOWN or RAMP_UP, or (state is RUN and volume≠target_vol). It is derived from registered state and volume.
- mute_req toggling mid-ramp reverses direction from the current volume. There is no jump and no restart from 0 or from the target.
- frame_tick held high for multiple cycles gives one step per high cycle. The block does not edge-detect.
- reset_n low mid-ramp: next edge forces the reset values regardless of tick or request.

## Timing
- All outputs are registered. volume and mute change on the clock edge after the qualifying input cycle.
- mute_req rise (in RUN) → state=RAMP_DOWN 1 cycle later. The first volume decrement happens on the first frame_tick after that.
- RAMP_DOWN reaching volume=0 → state=MUTED and mute=1 on the next edge. mute therefore never asserts while volume>0.
- mute_req fall (in MUTED) → state=RAMP_UP and mute=0 1 cycle later, with volume still 0.
- Full ramp 0→255 at STEP=1 takes 255 frame_ticks plus 1 cycle for the RAMP_UP→RUN transition.
- No combinational path from inputs to outputs.

## Test plan
- Reset release with mute_req=0, target_vol=8, STEP=1:
  - state=MUTED, mute=1 during reset.
  - Then RAMP_UP, mute=0, and volume reaches 8 after exactly 8 ticks.
  - RUN one cycle later, ramp_busy=0.
- In RUN at volume=200, assert mute_req, STEP=16:
  - Volume sequence 184,168,…,8,0 on successive ticks.
  - MUTED on the edge after 0, mute=1, muted_ack=1.
  - mute never 1 with volume≠0.
- In RAMP_DOWN at volume=100, drop mute_req, target=120, STEP=1:
  - RAMP_UP next cycle.
  - Volume 101…120 with no discontinuity, then RUN.
- Target change in RUN, STEP=7, volume=10 → target=3:
  - One tick gives volume=3 (no undershoot).
  - Then target=255 ramps 10,17,… and saturates at exactly 255.
- Simultaneous events: frame_tick coincides with the RUN→RAMP_DOWN transition → volume unchanged that cycle.
  - frame_tick held high 3 cycles → 3 steps.
- reset_n asserted mid-ramp at volume=77 → next edge gives volume=0, mute=1, state=MUTED.

Source files
------------

// File: rtl/volume_ramp_sequencer_if.sv
// rtl/volume_ramp_sequencer_if.sv - control and gain signals between controller and volume ramp sequencer
interface volume_ramp_sequencer_if;
    logic [7:0] target_vol;
    logic       mute_req;
    logic       frame_tick;
    logic [7:0] volume;
    logic       mute;
    logic [1:0] state;
    logic       ramp_busy;
    logic       muted_ack;

    modport master (
        output target_vol,
        output mute_req,
        output frame_tick,
        input  volume,
        input  mute,
        input  state,
        input  ramp_busy,
        input  muted_ack
    );

    modport slave (
        input  target_vol,
        input  mute_req,
        input  frame_tick,
        output volume,
        output mute,
        output state,
        output ramp_busy,
        output muted_ack
    );
endinterface

// File: rtl/volume_ramp_sequencer.sv
// rtl/volume_ramp_sequencer.sv - frame-paced volume ramping with pop-free mute/unmute sequencing
module volume_ramp_sequencer #(
    parameter int unsigned STEP = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    volume_ramp_sequencer_if.slave   vif
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_RAMP_DOWN = 2'd1,
        ST_MUTED     = 2'd2,
        ST_RAMP_UP   = 2'd3
    } state_t;

    localparam logic [8:0] STEP9 = 9'(STEP);

    state_t     state_q, state_d;
    logic [7:0] volume_q, volume_d;
    logic       mute_q, mute_d;
    logic       ramp_busy_q, ramp_busy_d;
    logic       muted_ack_q, muted_ack_d;

    logic [8:0] vol9, tgt9;
    logic [8:0] up_gap, dn_gap, up_amt, dn_amt, fall_amt;
    logic [7:0] vol_up, vol_dn, vol_fall;

    // Clamp a 9-bit intermediate back to the 8-bit gain range.
    function automatic logic [7:0] sat8(input logic [8:0] x);
        return x[8] ? 8'hFF : x[7:0];
    endfunction

    // Candidate next volumes: move toward target, or fall toward zero, by at most STEP.
    always_comb begin
        vol9     = {1'b0, volume_q};
        tgt9     = {1'b0, vif.target_vol};
        up_gap   = tgt9 - vol9;
        dn_gap   = vol9 - tgt9;
        up_amt   = (up_gap < STEP9) ? up_gap : STEP9;
        dn_amt   = (dn_gap < STEP9) ? dn_gap : STEP9;
        fall_amt = (vol9 < STEP9) ? vol9 : STEP9;
        vol_up   = sat8(vol9 + up_amt);
        vol_dn   = sat8(vol9 - dn_amt);
        vol_fall = sat8(vol9 - fall_amt);
    end

    // Next state: a state transition takes the cycle and blocks any volume step.
    always_comb begin
        state_d  = state_q;
        volume_d = volume_q;
        case (state_q)
            ST_RUN: begin
                if (vif.mute_req) begin
                    state_d = ST_RAMP_DOWN;
                end else if (vif.frame_tick) begin
                    if (tgt9 > vol9) begin
                        volume_d = vol_up;
                    end else if (tgt9 < vol9) begin
                        volume_d = vol_dn;
                    end
                end
            end
            ST_RAMP_DOWN: begin
                if (!vif.mute_req) begin
                    state_d = ST_RAMP_UP;
                end else if (volume_q == 8'd0) begin
                    state_d = ST_MUTED;
                end else if (vif.frame_tick) begin
                    volume_d = vol_fall;
                end
            end
            ST_MUTED: begin
                volume_d = 8'd0;
                if (!vif.mute_req) begin
                    state_d = ST_RAMP_UP;
                end
            end
            ST_RAMP_UP: begin
                if (vif.mute_req) begin
                    state_d = ST_RAMP_DOWN;
                end else if (volume_q >= vif.target_vol) begin
                    state_d = ST_RUN;
                end else if (vif.frame_tick) begin
                    volume_d = vol_up;
                end
            end
            default: begin
                state_d  = ST_MUTED;
                volume_d = 8'd0;
            end
        endcase

        mute_d      = (state_d == ST_MUTED);
        muted_ack_d = (state_d == ST_MUTED);
        ramp_busy_d = (state_d == ST_RAMP_DOWN) || (state_d == ST_RAMP_UP) ||
                      ((state_d == ST_RUN) && (volume_d != vif.target_vol));
    end

    // State and output registers; reset leaves the converter hard-muted at zero gain.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_MUTED;
            volume_q    <= 8'd0;
            mute_q      <= 1'b1;
            ramp_busy_q <= 1'b0;
            muted_ack_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            volume_q    <= volume_d;
            mute_q      <= mute_d;
            ramp_busy_q <= ramp_busy_d;
            muted_ack_q <= muted_ack_d;
        end
    end

    assign vif.volume    = volume_q;
    assign vif.mute      = mute_q;
    assign vif.state     = state_q;
    assign vif.ramp_busy = ramp_busy_q;
    assign vif.muted_ack = muted_ack_q;

endmodule

// File: tb/tb_volume_ramp_sequencer.sv
// tb/tb_volume_ramp_sequencer.sv - self-checking bench for volume_ramp_sequencer
module tb_volume_ramp_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] target;
    logic       mute_req;
    logic       frame_tick;

    always #5 clk = ~clk;

    volume_ramp_sequencer_if if0 ();
    volume_ramp_sequencer_if if1 ();
    volume_ramp_sequencer_if if2 ();

    assign if0.target_vol = target;
    assign if0.mute_req   = mute_req;
    assign if0.frame_tick = frame_tick;
    assign if1.target_vol = target;
    assign if1.mute_req   = mute_req;
    assign if1.frame_tick = frame_tick;
    assign if2.target_vol = target;
    assign if2.mute_req   = mute_req;
    assign if2.frame_tick = frame_tick;

    volume_ramp_sequencer #(.STEP(1))  dut0 (.clk(clk), .reset_n(reset_n), .vif(if0.slave));
    volume_ramp_sequencer #(.STEP(7))  dut1 (.clk(clk), .reset_n(reset_n), .vif(if1.slave));
    volume_ramp_sequencer #(.STEP(16)) dut2 (.clk(clk), .reset_n(reset_n), .vif(if2.slave));

    logic [7:0] d_vol [3];
    logic       d_mute [3];
    logic [1:0] d_state [3];
    logic       d_busy [3];
    logic       d_ack [3];

    assign d_vol[0] = if0.volume;    assign d_vol[1] = if1.volume;    assign d_vol[2] = if2.volume;
    assign d_mute[0] = if0.mute;     assign d_mute[1] = if1.mute;     assign d_mute[2] = if2.mute;
    assign d_state[0] = if0.state;   assign d_state[1] = if1.state;   assign d_state[2] = if2.state;
    assign d_busy[0] = if0.ramp_busy; assign d_busy[1] = if1.ramp_busy; assign d_busy[2] = if2.ramp_busy;
    assign d_ack[0] = if0.muted_ack; assign d_ack[1] = if1.muted_ack; assign d_ack[2] = if2.muted_ack;

    localparam int S_RUN = 0, S_DOWN = 1, S_MUTED = 2, S_UP = 3;

    int steps [3] = '{1, 7, 16};
    int m_state [3];
    int m_vol [3];
    bit m_busy [3];
    bit model_ok = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit         rst_n;
        bit         mr;
        logic [7:0] tgt;
        bit         tick;
        int         st;
        int         vol;
        bit         mu;
        bit         busy;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int clamp(input int d, input int lim);
        if (d > lim)  return lim;
        if (d < -lim) return -lim;
        return d;
    endfunction

    // Reference behaviour: gain moves toward a goal by at most STEP per tick,
    // except when a mode change consumes the cycle.
    function automatic void model_step(input int k);
        int s = m_state[k];
        int v = m_vol[k];
        int t = int'(target);
        if (!reset_n) begin
            s = S_MUTED;
            v = 0;
        end else begin
            case (s)
                S_RUN:   if (mute_req) s = S_DOWN;
                         else if (frame_tick) v = v + clamp(t - v, steps[k]);
                S_DOWN:  if (!mute_req) s = S_UP;
                         else if (v == 0) s = S_MUTED;
                         else if (frame_tick) v = v + clamp(0 - v, steps[k]);
                S_MUTED: if (!mute_req) s = S_UP;
                default: if (mute_req) s = S_DOWN;
                         else if (v >= t) s = S_RUN;
                         else if (frame_tick) v = v + clamp(t - v, steps[k]);
            endcase
        end
        m_state[k] = s;
        m_vol[k]   = v;
        m_busy[k]  = (s == S_DOWN) || (s == S_UP) || (s == S_RUN && v != t);
    endfunction

    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        if (!reset_n) model_ok = 1'b1;
        #1;
        if (model_ok) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("u%0d.state", k), 32'(d_state[k]), 32'(m_state[k]));
                check($sformatf("u%0d.volume", k), 32'(d_vol[k]), 32'(m_vol[k]));
                check($sformatf("u%0d.mute", k), 32'(d_mute[k]), 32'(m_state[k] == S_MUTED));
                check($sformatf("u%0d.muted_ack", k), 32'(d_ack[k]), 32'(m_state[k] == S_MUTED));
                check($sformatf("u%0d.ramp_busy", k), 32'(d_busy[k]), 32'(m_busy[k]));
                check($sformatf("u%0d.mute_with_gain", k), 32'(d_mute[k] && d_vol[k] != 8'd0), 32'd0);
            end
        end
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        cycle();
        reset_n = 1'b1;
    endtask

    task automatic ramp_to(input int k, input int val, input int limit);
        frame_tick = 1'b1;
        for (int i = 0; i < limit; i++) begin
            if (m_vol[k] == val) break;
            cycle();
        end
        frame_tick = 1'b0;
        check($sformatf("ramp_to_u%0d", k), 32'(d_vol[k]), 32'(val));
    endtask

    function automatic void add(input bit r, input bit mr, input int tg, input bit tk,
                                input int st, input int vol, input bit mu, input bit busy);
        vec_t v;
        v.rst_n = r; v.mr = mr; v.tgt = 8'(tg); v.tick = tk;
        v.st = st; v.vol = vol; v.mu = mu; v.busy = busy;
        tbl.push_back(v);
    endfunction

    initial begin
        reset_n    = 1'b0;
        target     = 8'd8;
        mute_req   = 1'b0;
        frame_tick = 1'b0;

        // Expected behaviour of the STEP=1 instance, one row per clock.
        add(0, 0, 8, 0, S_MUTED, 0, 1, 0);
        add(0, 0, 8, 1, S_MUTED, 0, 1, 0);
        add(1, 0, 8, 0, S_UP, 0, 0, 1);
        for (int i = 1; i <= 8; i++) add(1, 0, 8, 1, S_UP, i, 0, 1);
        add(1, 0, 8, 0, S_RUN, 8, 0, 0);
        add(1, 1, 8, 1, S_DOWN, 8, 0, 1);
        add(1, 1, 8, 1, S_DOWN, 7, 0, 1);
        add(1, 1, 8, 1, S_DOWN, 6, 0, 1);
        add(1, 1, 8, 1, S_DOWN, 5, 0, 1);
        add(1, 0, 8, 0, S_UP, 5, 0, 1);
        add(1, 0, 8, 1, S_UP, 6, 0, 1);
        add(1, 0, 4, 0, S_RUN, 6, 0, 1);
        add(1, 0, 4, 1, S_RUN, 5, 0, 1);
        add(1, 0, 4, 1, S_RUN, 4, 0, 0);
        add(1, 0, 4, 0, S_RUN, 4, 0, 0);
        add(1, 1, 4, 0, S_DOWN, 4, 0, 1);
        for (int i = 3; i >= 0; i--) add(1, 1, 4, 1, S_DOWN, i, 0, 1);
        add(1, 1, 4, 0, S_MUTED, 0, 1, 0);
        add(1, 1, 200, 1, S_MUTED, 0, 1, 0);
        add(1, 0, 200, 0, S_UP, 0, 0, 1);

        foreach (tbl[i]) begin
            reset_n    = tbl[i].rst_n;
            mute_req   = tbl[i].mr;
            target     = tbl[i].tgt;
            frame_tick = tbl[i].tick;
            cycle();
            check($sformatf("vec%0d.state", i), 32'(d_state[0]), 32'(tbl[i].st));
            check($sformatf("vec%0d.volume", i), 32'(d_vol[0]), 32'(tbl[i].vol));
            check($sformatf("vec%0d.mute", i), 32'(d_mute[0]), 32'(tbl[i].mu));
            check($sformatf("vec%0d.busy", i), 32'(d_busy[0]), 32'(tbl[i].busy));
            check($sformatf("vec%0d.ack", i), 32'(d_ack[0]), 32'(tbl[i].st == S_MUTED));
        end

        // STEP=16: mute from RUN at 200 ramps 184..8,0 then mutes.
        mute_req = 1'b0; target = 8'd200;
        do_reset();
        ramp_to(2, 200, 40);
        cycle();
        check("a.run", 32'(d_state[2]), S_RUN);
        mute_req = 1'b1;
        cycle();
        check("a.down", 32'(d_state[2]), S_DOWN);
        check("a.hold", 32'(d_vol[2]), 200);
        frame_tick = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            cycle();
            check($sformatf("a.vol%0d", i), 32'(d_vol[2]), 32'((200 - 16 * i) < 0 ? 0 : 200 - 16 * i));
        end
        frame_tick = 1'b0;
        cycle();
        check("a.muted", 32'(d_state[2]), S_MUTED);
        check("a.mute", 32'(d_mute[2]), 1);
        check("a.ack", 32'(d_ack[2]), 1);

        // STEP=1: unmute during RAMP_DOWN at 100 climbs 101..120 without a jump.
        mute_req = 1'b0; target = 8'd100;
        do_reset();
        ramp_to(0, 100, 300);
        cycle();
        mute_req = 1'b1;
        cycle();
        check("b.down", 32'(d_state[0]), S_DOWN);
        mute_req = 1'b0; target = 8'd120;
        cycle();
        check("b.up", 32'(d_state[0]), S_UP);
        check("b.vol0", 32'(d_vol[0]), 100);
        frame_tick = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            check($sformatf("b.vol%0d", i), 32'(d_vol[0]), 32'(100 + i));
        end
        frame_tick = 1'b0;
        cycle();
        check("b.run", 32'(d_state[0]), S_RUN);
        check("b.busy", 32'(d_busy[0]), 0);

        // STEP=7: no undershoot toward 3, then exact saturation at 255.
        target = 8'd10;
        do_reset();
        ramp_to(1, 10, 50);
        cycle();
        check("c.run", 32'(d_state[1]), S_RUN);
        target = 8'd3; frame_tick = 1'b1;
        cycle();
        check("c.low", 32'(d_vol[1]), 3);
        target = 8'd255;
        for (int i = 1; i <= 37; i++) begin
            cycle();
            check($sformatf("c.vol%0d", i), 32'(d_vol[1]), 32'(i > 36 ? 255 : 3 + 7 * i));
        end
        frame_tick = 1'b0;

        // STEP=1: reset in the middle of a ramp at 77.
        target = 8'd200;
        do_reset();
        ramp_to(0, 77, 200);
        reset_n = 1'b0; frame_tick = 1'b1;
        cycle();
        check("d.state", 32'(d_state[0]), S_MUTED);
        check("d.vol", 32'(d_vol[0]), 0);
        check("d.mute", 32'(d_mute[0]), 1);
        reset_n = 1'b1;

        // Random traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 39) == 0) mute_req = ~mute_req;
            if ($urandom_range(0, 63) == 0) target = 8'($urandom);
            frame_tick = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
